// File: rtl/cei_mochila_pkg.sv
// Shared system constants for the cei_mochila system bus and its bank arbiters.
package cei_mochila_pkg;

  localparam int SYSTEM_XBAR_NMASTER      = 7;
  localparam int LOG_SYSTEM_XBAR_NMASTER  = 3;
  localparam int BANK_ARB_MAX_OUTSTANDING = 2;

  typedef logic [LOG_SYSTEM_XBAR_NMASTER-1:0] bank_arb_idx_t;

endpackage

// File: rtl/cei_idx_fifo.sv
// Small circular FIFO holding the master index of each issued-but-unanswered bank transaction.
module cei_idx_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count == CNT_W'(DEPTH));
  assign empty_o = (count == '0);
  assign data_o  = mem[rd_ptr];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage carries no reset; validity is tracked solely by count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cei_bank_rr_arbiter.sv
// Round-robin arbiter sharing one single-ported memory bank among the system-bus masters,
// with in-order response routing via an outstanding-index FIFO.
module cei_bank_rr_arbiter
  import cei_mochila_pkg::*;
#(
  parameter int NMASTER         = SYSTEM_XBAR_NMASTER,
  parameter int MAX_OUTSTANDING = BANK_ARB_MAX_OUTSTANDING,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NMASTER-1:0]             m_req_i,
  input  logic [NMASTER-1:0]             m_we_i,
  input  logic [NMASTER-1:0][3:0]        m_be_i,
  input  logic [NMASTER-1:0][ADDR_W-1:0] m_addr_i,
  input  logic [NMASTER-1:0][DATA_W-1:0] m_wdata_i,
  output logic [NMASTER-1:0]             m_gnt_o,
  output logic [NMASTER-1:0]             m_rvalid_o,
  output logic [DATA_W-1:0]              m_rdata_o,
  output logic                           s_req_o,
  output logic                           s_we_o,
  output logic [3:0]                     s_be_o,
  output logic [ADDR_W-1:0]              s_addr_o,
  output logic [DATA_W-1:0]              s_wdata_o,
  input  logic                           s_gnt_i,
  input  logic                           s_rvalid_i,
  input  logic [DATA_W-1:0]              s_rdata_i,
  output logic                           resp_err_o
);

  localparam int IDX_W = (NMASTER > 1) ? $clog2(NMASTER) : 1;
  typedef logic [IDX_W-1:0] idx_t;

  idx_t rr_ptr, win, head;
  logic any_req, full, empty, handshake, pop;
  int   idx;

  // Descending scan so the candidate closest above rr_ptr is the last to overwrite win.
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = NMASTER - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NMASTER) idx = idx - NMASTER;
      if (m_req_i[idx]) begin
        win     = idx_t'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign s_req_o   = any_req && !full;
  assign handshake = s_req_o && s_gnt_i;
  assign pop       = s_rvalid_i && !empty;

  assign s_we_o    = m_we_i[win];
  assign s_be_o    = m_be_i[win];
  assign s_addr_o  = m_addr_i[win];
  assign s_wdata_o = m_wdata_i[win];
  assign m_rdata_o = s_rdata_i;

  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    if (handshake) m_gnt_o[win]    = 1'b1;
    if (pop)       m_rvalid_o[head] = 1'b1;
  end

  cei_idx_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IDX_W)
  ) u_idx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (handshake),
    .pop_i   (pop),
    .data_i  (win),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Pointer moves past the winner only when served, so a stalled requester keeps priority.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr     <= '0;
      resp_err_o <= 1'b0;
    end else begin
      if (handshake)
        rr_ptr <= (win == idx_t'(NMASTER - 1)) ? '0 : win + 1'b1;
      if (s_rvalid_i && empty)
        resp_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cei_bank_rr_arbiter.sv
// Directed self-checking bench for cei_bank_rr_arbiter.
module tb_cei_bank_rr_arbiter;

  localparam int N  = 7;
  localparam int AW = 32;
  localparam int DW = 32;

  logic                   clk;
  logic                   rst_ni;
  logic [N-1:0]           m_req, m_we, m_gnt, m_rvalid;
  logic [N-1:0][3:0]      m_be;
  logic [N-1:0][AW-1:0]   m_addr;
  logic [N-1:0][DW-1:0]   m_wdata;
  logic [DW-1:0]          m_rdata;
  logic                   s_req, s_we, s_gnt, s_rvalid, resp_err;
  logic [3:0]             s_be;
  logic [AW-1:0]          s_addr;
  logic [DW-1:0]          s_wdata, s_rdata;

  int checks = 0;
  int errors = 0;
  int prev;
  int exp_w;

  cei_bank_rr_arbiter #(
    .NMASTER (N), .MAX_OUTSTANDING (2), .ADDR_W (AW), .DATA_W (DW)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .m_req_i    (m_req),
    .m_we_i     (m_we),
    .m_be_i     (m_be),
    .m_addr_i   (m_addr),
    .m_wdata_i  (m_wdata),
    .m_gnt_o    (m_gnt),
    .m_rvalid_o (m_rvalid),
    .m_rdata_o  (m_rdata),
    .s_req_o    (s_req),
    .s_we_o     (s_we),
    .s_be_o     (s_be),
    .s_addr_o   (s_addr),
    .s_wdata_o  (s_wdata),
    .s_gnt_i    (s_gnt),
    .s_rvalid_i (s_rvalid),
    .s_rdata_i  (s_rdata),
    .resp_err_o (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_ni   = 1'b0;
    m_req    = '0;
    s_gnt    = 1'b0;
    s_rvalid = 1'b0;
    s_rdata  = '0;
    for (int i = 0; i < N; i++) begin
      m_we[i]    = i[0];
      m_be[i]    = 4'(i + 1);
      m_addr[i]  = 32'h0000_1000 + 32'(i * 4);
      m_wdata[i] = 32'hA5A5_0000 + 32'(i);
    end

    // Reset state
    tick(); tick(); settle();
    chk("rst_s_req", 32'(s_req), 0);
    chk("rst_gnt", 32'(m_gnt), 0);
    chk("rst_rvalid", 32'(m_rvalid), 0);
    chk("rst_err", 32'(resp_err), 0);
    rst_ni = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    settle();
    chk("idle_s_req", 32'(s_req), 0);
    chk("idle_gnt", 32'(m_gnt), 0);
    chk("idle_rvalid", 32'(m_rvalid), 0);
    chk("idle_err", 32'(resp_err), 0);

    // Masters 1 and 5, bank grants always and answers one cycle later
    m_req = 7'b010_0010;
    s_gnt = 1'b1;
    prev  = -1;
    for (int g = 0; g < 4; g++) begin
      exp_w    = (g % 2 == 0) ? 1 : 5;
      s_rvalid = (prev >= 0);
      s_rdata  = (prev >= 0) ? 32'hA5A5_0000 + 32'(prev) : 32'h0;
      settle();
      chk("p15_gnt", 32'(m_gnt), 32'(1) << exp_w);
      chk("p15_wdata", s_wdata, 32'hA5A5_0000 + 32'(exp_w));
      chk("p15_addr", s_addr, 32'h0000_1000 + 32'(exp_w * 4));
      chk("p15_rvalid", 32'(m_rvalid), (prev >= 0) ? (32'(1) << prev) : 32'h0);
      if (prev >= 0) chk("p15_rdata", m_rdata, 32'hA5A5_0000 + 32'(prev));
      prev = exp_w;
      tick();
    end
    m_req    = '0;
    s_rvalid = 1'b1;
    s_rdata  = 32'hA5A5_0005;
    settle();
    chk("p15_last_rvalid", 32'(m_rvalid), 32'h20);
    chk("p15_last_rdata", m_rdata, 32'hA5A5_0005);
    chk("p15_last_gnt", 32'(m_gnt), 0);
    tick();
    s_rvalid = 1'b0;

    // Reset pointer to 0, then all masters request
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    m_req  = '1;
    prev   = -1;
    for (int g = 0; g < 8; g++) begin
      exp_w    = g % N;
      s_rvalid = (prev >= 0);
      s_rdata  = (prev >= 0) ? 32'hA5A5_0000 + 32'(prev) : 32'h0;
      settle();
      chk("all_gnt", 32'(m_gnt), 32'(1) << exp_w);
      chk("all_be", 32'(s_be), 32'(exp_w + 1));
      chk("all_we", 32'(s_we), 32'(exp_w % 2));
      chk("all_rvalid", 32'(m_rvalid), (prev >= 0) ? (32'(1) << prev) : 32'h0);
      prev = exp_w;
      tick();
    end
    m_req    = '0;
    s_rvalid = 1'b1;
    s_rdata  = 32'hA5A5_0000;
    settle();
    chk("all_last_rvalid", 32'(m_rvalid), 32'h01);
    tick();
    s_rvalid = 1'b0;

    // Outstanding limit: rr_ptr = 1, masters 2 and 4, bank silent
    m_req = 7'b001_0100;
    settle();
    chk("full_gnt0", 32'(m_gnt), 32'h04);
    tick(); settle();
    chk("full_gnt1", 32'(m_gnt), 32'h10);
    tick(); settle();
    chk("full_s_req", 32'(s_req), 0);
    chk("full_gnt_blk", 32'(m_gnt), 0);
    tick();
    s_rvalid = 1'b1;
    s_rdata  = 32'h1111_2222;
    settle();
    chk("full_pop_rvalid", 32'(m_rvalid), 32'h04);
    chk("full_pop_s_req", 32'(s_req), 0);
    chk("full_pop_gnt", 32'(m_gnt), 0);
    tick();
    s_rvalid = 1'b0;
    settle();
    chk("full_after_pop_gnt", 32'(m_gnt), 32'h04);
    tick();
    m_req    = '0;
    s_rvalid = 1'b1;
    settle();
    chk("full_drain0", 32'(m_rvalid), 32'h10);
    tick(); settle();
    chk("full_drain1", 32'(m_rvalid), 32'h04);
    tick();
    s_rvalid = 1'b0;

    // rr_ptr = 3 now, masters 2 and 6
    m_req = 7'b100_0100;
    settle();
    chk("ptr3_gnt6", 32'(m_gnt), 32'h40);
    tick();
    s_rvalid = 1'b1;
    s_rdata  = 32'hA5A5_0006;
    settle();
    chk("ptr3_gnt2", 32'(m_gnt), 32'h04);
    chk("ptr3_rvalid6", 32'(m_rvalid), 32'h40);
    tick();
    m_req = '0;
    settle();
    chk("ptr3_rvalid2", 32'(m_rvalid), 32'h04);
    chk("ptr3_err", 32'(resp_err), 0);
    tick();
    s_rvalid = 1'b0;
    tick();

    // Unsolicited response with empty FIFO
    s_rvalid = 1'b1;
    s_rdata  = 32'hDEAD_BEEF;
    settle();
    chk("err_rvalid", 32'(m_rvalid), 0);
    chk("err_before", 32'(resp_err), 0);
    tick();
    s_rvalid = 1'b0;
    settle();
    chk("err_set", 32'(resp_err), 1);
    tick(); tick(); tick(); settle();
    chk("err_sticky", 32'(resp_err), 1);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    settle();
    chk("err_cleared", 32'(resp_err), 0);
    chk("final_s_req", 32'(s_req), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
